// File: rtl/bf16_pkg.sv
// Shared bfloat16 field layout and special encodings for the rounding datapath.
package bf16_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_HI   = 14;
  localparam int EXP_LO   = 7;
  localparam int FRAC_HI  = 6;
  localparam int FRAC_LO  = 0;

  localparam logic [7:0] EXP_SPECIAL = 8'hFF;
  localparam logic [6:0] FRAC_ALL1   = 7'h7F;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

endpackage

// File: rtl/bf16_round_arbiter_if.sv
// Requester and result channels of the shared bf16 rounding unit.
interface bf16_round_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*16-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  res_valid;
  logic [15:0]           res_data;
  logic [ID_W-1:0]       res_id;
  logic                  res_ready;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id
  );

endinterface

// File: rtl/bf16_round_core.sv
// Combinational bf16 round-to-nearest on the LSB of the fraction, with carry into the exponent.
module bf16_round_core
  import bf16_pkg::*;
#(
  parameter int ROUND_MIN_EXP = 10
) (
  input  bf16_t din,
  output bf16_t dout
);

  function automatic bf16_t round_bf16(input logic [15:0] x);
    logic       s;
    logic [7:0] e;
    logic [6:0] f;
    bf16_t      r;
    s = x[SIGN_BIT];
    e = x[EXP_HI:EXP_LO];
    f = x[FRAC_HI:FRAC_LO];
    r = bf16_t'(x);
    // NaN/Inf and small exponents pass through untouched
    if ((e != EXP_SPECIAL) && (int'(e) >= ROUND_MIN_EXP) && f[FRAC_LO]) begin
      if (f == FRAC_ALL1) begin
        r = '{sign: s, exp: e + 8'd1, frac: 7'h00};
      end else begin
        r = '{sign: s, exp: e, frac: f + 7'd1};
      end
    end
    return r;
  endfunction

  assign dout = round_bf16(din);

endmodule

// File: rtl/bf16_round_arbiter.sv
// Round-robin arbiter in front of a shared 2-stage bf16 rounding pipeline with op counter.
module bf16_round_arbiter
  import bf16_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int ROUND_MIN_EXP = 10,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  bf16_round_arbiter_if.slave bus,
  output logic [CNT_W-1:0] ops_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic               vld_p1;
  bf16_t              data_p1;
  logic [ID_W-1:0]    id_p1;
  logic               vld_p2;
  bf16_t              data_p2;
  logic [ID_W-1:0]    id_p2;
  logic [ID_W-1:0]    last_gnt;

  logic               s2_free;
  logic               s1_adv;
  logic               s1_open;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt_vec;
  logic               fire;
  bf16_t              operand;
  bf16_t              rounded;
  int                 scan_idx;

  assign s2_free = !vld_p2 || bus.res_ready;
  assign s1_adv  = vld_p1 && s2_free;
  assign s1_open = !vld_p1 || s1_adv;

  // Search starts just after the last winner so every requester gets a turn
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(last_gnt) + k) % NUM_REQ;
      if (!gnt_found && bus.req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(scan_idx);
      end
    end
  end

  assign fire = rst_n && s1_open && gnt_found;

  always_comb begin
    gnt_vec = '0;
    if (fire) gnt_vec[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = gnt_vec;
  assign operand       = bf16_t'(bus.req_data[16*gnt_idx +: 16]);

  // Stage 1: captured operand and requester id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      last_gnt <= ID_W'(NUM_REQ - 1);
    end else if (fire) begin
      vld_p1   <= 1'b1;
      last_gnt <= gnt_idx;
    end else if (s1_adv) begin
      vld_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      data_p1 <= operand;
      id_p1   <= gnt_idx;
    end
  end

  bf16_round_core #(
    .ROUND_MIN_EXP (ROUND_MIN_EXP)
  ) u_round (
    .din  (data_p1),
    .dout (rounded)
  );

  // Stage 2: rounded result driving the result channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      id_p2   <= '0;
    end else if (s1_adv) begin
      vld_p2  <= 1'b1;
      data_p2 <= rounded;
      id_p2   <= id_p1;
    end else if (bus.res_ready) begin
      vld_p2  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_count <= '0;
    end else if (vld_p2 && bus.res_ready) begin
      ops_count <= sat_inc(ops_count);
    end
  end

  assign bus.res_valid = vld_p2;
  assign bus.res_data  = data_p2;
  assign bus.res_id    = id_p2;

endmodule

// File: tb/tb_bf16_round_arbiter.sv
// Directed + randomized bench for bf16_round_arbiter with a transaction-level reference model.
module tb_bf16_round_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [15:0] data;
    int          id;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CNT_W-1:0] ops_count;

  always #5 clk = ~clk;

  bf16_round_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  bf16_round_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .ID_W          (ID_W),
    .ROUND_MIN_EXP (10),
    .CNT_W         (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ops_count (ops_count)
  );

  int               tests = 0;
  int               fails = 0;
  exp_t             q[$];
  int               rr_last;
  int               model_cnt;
  int               n_deliv;
  logic [15:0]      op[NUM_REQ];
  logic [NUM_REQ-1:0] pend;
  logic             rdy;
  logic             stall_prev;
  logic [15:0]      prev_data;
  logic [ID_W-1:0]  prev_id;
  logic             s_fire;
  int               s_gnt_id;
  logic             s_res_valid;
  logic             s_deliv;
  logic [15:0]      last_out;
  int               fires;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference rounding: increment the 15-bit magnitude; the carry ripples into the exponent
  function automatic logic [15:0] ref_round(input logic [15:0] x);
    logic [7:0] e;
    e = x[14:7];
    if (e != 8'hFF && e >= 8'd10 && x[0]) return {x[15], x[14:0] + 15'd1};
    return x;
  endfunction

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] x;
    x = 16'($urandom);
    case ($urandom_range(0, 5))
      0: x[6:0]  = 7'h7F;
      1: x[14:7] = 8'hFE;
      2: x[14:7] = 8'hFF;
      3: x[14:7] = 8'($urandom_range(0, 12));
      default: ;
    endcase
    return x;
  endfunction

  task automatic apply();
    bus.req_valid = pend;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[16*i +: 16] = op[i];
    bus.res_ready = rdy;
  endtask

  task automatic model_reset();
    q.delete();
    rr_last    = NUM_REQ - 1;
    model_cnt  = 0;
    stall_prev = 1'b0;
  endtask

  // One clock: drive at the falling edge, sample 2ns later, return at the next falling edge
  task automatic step();
    int inflight;
    int pick;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [NUM_REQ-1:0] gnt;
    exp_t e;
    apply();
    #2;
    inflight = q.size();
    chk("ops_count", 32'(ops_count), 32'(model_cnt));
    if (stall_prev) begin
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_data", 32'(bus.res_data), 32'(prev_data));
      chk("hold_id", 32'(bus.res_id), 32'(prev_id));
    end
    s_res_valid = bus.res_valid;
    s_deliv     = 1'b0;
    if (bus.res_valid && bus.res_ready) begin
      chk("result_expected", 32'(inflight > 0), 32'd1);
      if (inflight > 0) begin
        e = q.pop_front();
        chk("res_data", 32'(bus.res_data), 32'(e.data));
        chk("res_id", 32'(bus.res_id), 32'(e.id));
      end
      last_out = bus.res_data;
      s_deliv  = 1'b1;
      n_deliv++;
      if (model_cnt < CNT_MAX) model_cnt++;
    end
    // Two result slots: a new operand fits unless both are full and the output is stalled
    exp_rdy = '0;
    pick = rr_pick(rr_last, bus.req_valid);
    if (pick >= 0 && (inflight < 2 || bus.res_ready)) exp_rdy[pick] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    gnt    = bus.req_valid & bus.req_ready;
    s_fire = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] && !s_fire) begin
        s_fire   = 1'b1;
        s_gnt_id = i;
        q.push_back('{data: ref_round(op[i]), id: i});
        rr_last  = i;
        pend[i]  = 1'b0;
      end
    end
    stall_prev = bus.res_valid && !bus.res_ready;
    prev_data  = bus.res_data;
    prev_id    = bus.res_id;
    @(negedge clk);
  endtask

  task automatic drain();
    pend = '0;
    rdy  = 1'b1;
    for (int n = 0; n < 40 && q.size() > 0; n++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pend  = '1;
    rdy   = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) op[i] = rand_op();
    apply();
    #2;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    chk("rst_ops_count", 32'(ops_count), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    model_reset();
    pend = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_one(input string tag, input int id, input logic [15:0] x,
                          input logic [15:0] expv);
    int n;
    pend[id] = 1'b1;
    op[id]   = x;
    rdy      = 1'b1;
    n        = 0;
    step();
    while (!s_deliv && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_delivered"}, 32'(s_deliv), 32'd1);
    chk(tag, 32'(last_out), 32'(expv));
  endtask

  initial begin
    rst_n   = 1'b1;
    pend    = '0;
    rdy     = 1'b1;
    n_deliv = 0;
    for (int i = 0; i < NUM_REQ; i++) op[i] = '0;
    apply();
    model_reset();
    #1 rst_n = 1'b0;
    do_reset();

    // Single request from requester 0
    pend[0] = 1'b1;
    op[0]   = 16'h4501;
    step();
    chk("t1_fire", 32'(s_fire), 32'd1);
    chk("t1_gnt", 32'(s_gnt_id), 32'd0);
    step();
    chk("t1_not_yet", 32'(s_res_valid), 32'd0);
    step();
    chk("t1_valid", 32'(s_res_valid), 32'd1);
    chk("t1_data", 32'(last_out), 32'h4502);
    chk("t1_ops", 32'(ops_count), 32'd1);
    drain();

    // Rounding corner cases
    send_one("t2_carry", 1, 16'h457F, 16'h4580);
    send_one("t2_inf", 2, 16'h7F7F, 16'h7F80);
    send_one("t2_nan", 3, 16'h7FC1, 16'h7FC1);
    send_one("t2_small", 0, 16'h0281, 16'h0281);
    drain();

    // All requesters valid, output always ready
    do_reset();
    pend = '1;
    for (int i = 0; i < NUM_REQ; i++) op[i] = rand_op();
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t3_gnt", s_fire ? 32'(s_gnt_id) : 32'hFFFF_FFFF, 32'(c % NUM_REQ));
      if (c >= 2) chk("t3_nobubble", 32'(s_res_valid), 32'd1);
      if (s_fire) begin
        pend[s_gnt_id] = 1'b1;
        op[s_gnt_id]   = rand_op();
      end
    end
    drain();

    // Backpressure from an empty pipeline
    pend  = '1;
    rdy   = 1'b0;
    fires = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (s_fire) begin
        fires++;
        pend[s_gnt_id] = 1'b1;
        op[s_gnt_id]   = rand_op();
      end
    end
    chk("t4_accepted", 32'(fires), 32'd2);
    drain();

    // Asynchronous reset with both stages full
    pend = '1;
    rdy  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (s_fire) pend[s_gnt_id] = 1'b1;
    end
    apply();
    #2;
    chk("t5_full", 32'(bus.res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("t5_rst_count", 32'(ops_count), 32'd0);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pend  = '1;
    rdy   = 1'b1;
    step();
    chk("t5_first_gnt", s_fire ? 32'(s_gnt_id) : 32'hFFFF_FFFF, 32'd0);
    drain();

    // Counter saturation after 20 more results
    begin
      int target;
      target = n_deliv + 20;
      rdy = 1'b1;
      for (int n = 0; n < 200 && n_deliv < target; n++) begin
        for (int i = 0; i < NUM_REQ; i++)
          if (!pend[i] && (n_deliv + q.size() + 1 < target + 1) && $urandom_range(0, 1) == 1) begin
            pend[i] = 1'b1;
            op[i]   = rand_op();
          end
        step();
      end
      chk("t6_results", 32'(n_deliv), 32'(target));
    end
    drain();
    chk("t6_saturated", 32'(ops_count), 32'(CNT_MAX));

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          op[i]   = rand_op();
        end
      step();
    end
    for (int n = 0; n < 20 && pend != '0; n++) begin
      rdy = 1'b1;
      step();
    end
    chk("rand_all_granted", 32'(pend), 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
